fc_layer: RTL

FC_LAYER -- requirements
Module: fc_layer

---
 rtl/lenet_pkg.sv | 36 +++
 rtl/fc_mac.sv | 56 +++++
 rtl/fc_layer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer blocks: one-hot FSM encoding for the
// fully connected layer and the saturation width constants with helpers.
package lenet_pkg;

   // Bit positions of the one-hot FC layer states
   localparam int S_IDLE      = 0;
   localparam int S_LOAD_BIAS = 1;
   localparam int S_MAC       = 2;
   localparam int S_DRAIN     = 3;
   localparam int S_STORE     = 4;
   localparam int S_FINISH    = 5;
   localparam int N_STATES    = 6;

   typedef enum logic [N_STATES-1:0] {
      IDLE      = 6'(1 << S_IDLE),
      LOAD_BIAS = 6'(1 << S_LOAD_BIAS),
      MAC       = 6'(1 << S_MAC),
      DRAIN     = 6'(1 << S_DRAIN),
      STORE     = 6'(1 << S_STORE),
      FINISH    = 6'(1 << S_FINISH)
   } fc_state_t;

   // Saturation target width (signed data) and accumulator width
   localparam int SAT_W     = 8;
   localparam int ACC_W_DEF = 24;

   // Largest and smallest value representable in a signed w-bit word
   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate-saturate datapath for one neuron: bias preload,
// signed product accumulation (wrapping) and shift-then-clamp output.
module fc_mac
   import lenet_pkg::*;
#(
   parameter int DATA_W    = SAT_W,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int FRAC_BITS = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     load_bias,
   input  logic signed [DATA_W-1:0] bias,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic                     vld,
   output logic signed [ACC_W-1:0]  acc_out,
   output logic signed [DATA_W-1:0] sat_out
);

   localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_W));
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_W));

   logic signed [ACC_W-1:0]    acc;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    shifted;

   assign prod     = a * b;
   assign prod_ext = ACC_W'(prod);   // signed cast sign-extends
   assign shifted  = acc >>> FRAC_BITS;
   assign acc_out  = acc;

   // Accumulator: bias preload, then one product per valid beat
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst || clr)
         acc <= '0;
      else if (load_bias)
         acc <= ACC_W'(bias);
      else if (vld)
         acc <= acc + prod_ext;
   end

   // Clamp the scaled accumulator into the signed output range
   always_comb begin
      // NOTE: the default assignment up front keeps this block free of inferred latches.
      sat_out = shifted[DATA_W-1:0];
      if (shifted > HI)
         sat_out = HI[DATA_W-1:0];
      else if (shifted < LO)
         sat_out = LO[DATA_W-1:0];
   end

endmodule

// File: rtl/fc_layer.sv
// Fully connected layer sequencer: streams inputs and weights from BRAM, one
// MAC per cycle, and writes one saturated result per neuron.
// Optional build macro FC_RELU_EN applies ReLU to each stored result.
module fc_layer
   import lenet_pkg::*;
#(
   parameter int IN_SIZE   = 800,
   parameter int OUT_SIZE  = 500,
   parameter int DATA_W    = SAT_W,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int FRAC_BITS = 0,
   parameter int RD_LAT    = 2,
   parameter int IN_BASE   = 17600,
   parameter int W_BASE    = 25500,
   parameter int B_BASE    = 430570,
   parameter int OUT_BASE  = 18400
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              bw_bram_ena,
   output logic [18:0]       bw_bram_addra,
   input  logic [DATA_W-1:0] bw_bram_douta,
   output logic              res_bram_ena,
   output logic              res_bram_wea,
   output logic [14:0]       res_bram_addra,
   output logic [DATA_W-1:0] res_bram_dina,
   input  logic [DATA_W-1:0] res_bram_douta,
   output logic              busy,
   output logic              done
);

`ifdef FC_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   localparam int CNT_MAX = (IN_SIZE > RD_LAT + 1) ? IN_SIZE : RD_LAT + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ROW_W   = $clog2(OUT_SIZE + 1);

   fc_state_t                state, next_state;
   logic [CNT_W-1:0]         cnt;
   logic [ROW_W-1:0]         row;
   logic [18:0]              w_ptr;
   logic [RD_LAT-1:0]        vld_pipe;
   logic                     issue, load_bias, clr;
   logic signed [ACC_W-1:0]  acc_val;
   logic signed [DATA_W-1:0] sat_val, store_val;

   // ReLU zeroes the result exactly when the accumulator is negative
   assign store_val = (RELU_EN && (acc_val < ACC_W'(0))) ? '0 : sat_val;
   assign clr       = (state == IDLE);

   // State register, phase/row counters, weight pointer and read-valid pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         row      <= '0;
         w_ptr    <= '0;
         vld_pipe <= '0;
      end else begin
         state <= next_state;
         if (next_state != state || state == IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (state == IDLE && start) begin
            row   <= '0;
            w_ptr <= 19'(W_BASE);
         end
         if (issue)
            w_ptr <= w_ptr + 19'd1;
         if (state == STORE)
            row <= row + ROW_W'(1);
         vld_pipe[0] <= issue;
         for (int i = 1; i < RD_LAT; i++)
            vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // Next-state decode and Moore outputs; everything is forced low during reset
   always_comb begin
      next_state     = state;
      bw_bram_ena    = 1'b0;
      bw_bram_addra  = '0;
      res_bram_ena   = 1'b0;
      res_bram_wea   = 1'b0;
      res_bram_addra = '0;
      res_bram_dina  = '0;
      busy           = 1'b0;
      done           = 1'b0;
      issue          = 1'b0;
      load_bias      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               next_state = LOAD_BIAS;
         end
         LOAD_BIAS: begin
            busy = 1'b1;
            if (cnt == '0) begin
               bw_bram_ena   = 1'b1;
               bw_bram_addra = 19'(B_BASE + int'(row));
            end
            if (cnt == CNT_W'(RD_LAT)) begin
               load_bias  = 1'b1;
               next_state = MAC;
            end
         end
         MAC: begin
            busy           = 1'b1;
            issue          = 1'b1;
            bw_bram_ena    = 1'b1;
            bw_bram_addra  = w_ptr;
            res_bram_ena   = 1'b1;
            res_bram_addra = 15'(IN_BASE + int'(cnt));
            if (cnt == CNT_W'(IN_SIZE - 1))
               next_state = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(RD_LAT))
               next_state = STORE;
         end
         STORE: begin
            busy           = 1'b1;
            res_bram_ena   = 1'b1;
            res_bram_wea   = 1'b1;
            res_bram_addra = 15'(OUT_BASE + int'(row));
            res_bram_dina  = store_val;
            next_state     = (row == ROW_W'(OUT_SIZE - 1)) ? FINISH : LOAD_BIAS;
         end
         FINISH: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (rst) begin
         bw_bram_ena    = 1'b0;
         bw_bram_addra  = '0;
         res_bram_ena   = 1'b0;
         res_bram_wea   = 1'b0;
         res_bram_addra = '0;
         res_bram_dina  = '0;
         busy           = 1'b0;
         done           = 1'b0;
         issue          = 1'b0;
         load_bias      = 1'b0;
      end
   end

   fc_mac #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .FRAC_BITS(FRAC_BITS)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load_bias(load_bias),
      .bias     (bw_bram_douta),
      .a        (res_bram_douta),
      .b        (bw_bram_douta),
      .vld      (vld_pipe[RD_LAT-1]),
      .acc_out  (acc_val),
      .sat_out  (sat_val)
   );

endmodule
